// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its reader/writer engines.
package instr_register_pkg;

  // Register depth implied by the address width.
  localparam int ADDR_W = 5;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [ADDR_W-1:0]  address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    OUTPUT = 3'd3,
    DONE   = 3'd4
  } reader_state_t;

  // Sign-extend a 32-bit operand to the 64-bit result domain.
  function automatic result_t widen(input operand_t v);
    return {{32{v[31]}}, v};
  endfunction

  // DIV and MOD are the only opcodes that can fault on a zero divisor.
  function automatic logic is_div_op(input opcode_t opc);
    return (opc == DIV) || (opc == MOD);
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational opcode executor: one instruction in, 64-bit result and
// divide-by-zero flag out. Shared with other execution blocks.
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t instr,
  output result_t      res,
  output logic         err
);

  result_t a_ext;
  result_t b_ext;

  assign a_ext = widen(instr.op_a);
  assign b_ext = widen(instr.op_b);

  // Evaluate the opcode; undefined encodings fall through to zero.
  always_comb begin
    // NOTE: defaults first so every path assigns res/err; a missed branch would otherwise infer a latch.
    res = '0;
    err = 1'b0;
    if (is_div_op(instr.opc) && (instr.op_b == '0)) begin
      err = 1'b1;
    end else begin
      case (instr.opc)
        ZERO:    res = '0;
        PASSA:   res = a_ext;
        PASSB:   res = b_ext;
        ADD:     res = a_ext + b_ext;
        SUB:     res = a_ext - b_ext;
        // Both operands are sign-extended to 64 bits, so the truncated
        // 64-bit product equals the full signed 32x32 product.
        MULT:    res = a_ext * b_ext;
        // Signed division truncates toward zero; the remainder takes the
        // dividend's sign. Widening first keeps -2^31 / -1 from overflowing.
        DIV:     res = a_ext / b_ext;
        MOD:     res = a_ext % b_ext;
        default: res = '0;
      endcase
    end
  end

endmodule

// File: rtl/instr_reader.sv
// Read-side engine for the instruction register: walks read_pointer over a
// programmed window, executes each entry and hands results downstream on a
// valid/ready handshake.
module instr_reader
  import instr_register_pkg::*;
#(
  parameter int NUM_ENTRIES = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  address_t         start_addr,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output address_t         read_pointer,
  input  instruction_t     instruction_word,
  output logic             out_valid,
  input  logic             out_ready,
  output address_t         out_addr,
  output opcode_t          out_opcode,
  output result_t          out_res,
  output logic             out_err,
  output logic             busy,
  output logic             done
);

  // A window longer than the register would revisit entries; cap it.
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(NUM_ENTRIES);

  reader_state_t    state;
  instruction_t     iw_q;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] count_eff;
  result_t          alu_res;
  logic             alu_err;

  assign count_eff = (count > MAX_COUNT) ? MAX_COUNT : count;
  assign busy      = (state != IDLE);

  instr_alu u_alu (
    .instr (iw_q),
    .res   (alu_res),
    .err   (alu_err)
  );

  // Reader FSM with all outputs registered; abort preempts every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      read_pointer <= '0;
      remaining    <= '0;
      iw_q         <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_opcode   <= ZERO;
      out_res      <= '0;
      out_err      <= 1'b0;
      done         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      done <= 1'b0;
      if (abort) begin
        // read_pointer deliberately holds so the abort point stays visible.
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (count == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                read_pointer <= start_addr;
                remaining    <= count_eff;
                state        <= FETCH;
              end
            end
          end
          FETCH: begin
            // The register read is combinational on read_pointer.
            iw_q  <= instruction_word;
            state <= EXEC;
          end
          EXEC: begin
            out_res    <= alu_res;
            out_err    <= alu_err;
            out_opcode <= iw_q.opc;
            out_addr   <= read_pointer;
            out_valid  <= 1'b1;
            state      <= OUTPUT;
          end
          OUTPUT: begin
            if (out_valid && out_ready) begin
              out_valid    <= 1'b0;
              read_pointer <= read_pointer + address_t'(1);
              remaining    <= remaining - CNT_W'(1);
              if (remaining == CNT_W'(1)) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= FETCH;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_reader.sv
// Self-checking bench for instr_reader: directed scenarios plus randomized
// windows compared against a reference model of the register contents.
module tb_instr_reader;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  address_t     start_addr;
  logic [5:0]   count;
  logic         abort;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         out_valid;
  logic         out_ready;
  address_t     out_addr;
  opcode_t      out_opcode;
  result_t      out_res;
  logic         out_err;
  logic         busy;
  logic         done;

  typedef struct {
    address_t addr;
    opcode_t  opc;
    result_t  res;
    logic     err;
  } exp_t;

  instruction_t mem [32];
  exp_t         expq [$];
  result_t      obs_res [$];
  logic         obs_err [$];
  address_t     obs_addr [$];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Zero-latency instruction register model.
  assign instruction_word = mem[read_pointer];

  instr_reader #(.NUM_ENTRIES(32), .CNT_W(6)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_addr       (start_addr),
    .count            (count),
    .abort            (abort),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_addr         (out_addr),
    .out_opcode       (out_opcode),
    .out_res          (out_res),
    .out_err          (out_err),
    .busy             (busy),
    .done             (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    instruction_t t;
    t.opc  = o;
    t.op_a = a;
    t.op_b = b;
    return t;
  endfunction

  // Reference arithmetic from the opcode definitions, in plain longint math.
  function automatic void model(input instruction_t i, output result_t r, output logic e);
    longint a;
    longint b;
    a = longint'(i.op_a);
    b = longint'(i.op_b);
    r = 0;
    e = 1'b0;
    case (int'(i.opc))
      0: r = 0;
      1: r = a;
      2: r = b;
      3: r = a + b;
      4: r = a - b;
      5: r = a * b;
      6: if (b == 0) e = 1'b1; else r = a / b;
      7: if (b == 0) e = 1'b1; else r = a % b;
      default: r = 0;
    endcase
  endfunction

  task automatic build_expect(input address_t sa, input int cnt);
    exp_t x;
    expq.delete();
    for (int i = 0; i < cnt; i++) begin
      x.addr = address_t'((int'(sa) + i) % 32);
      x.opc  = mem[x.addr].opc;
      model(mem[x.addr], x.res, x.err);
      expq.push_back(x);
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) begin
      int b;
      b = ($urandom_range(3) == 0) ? 0 : int'($urandom);
      mem[i] = mk(opcode_t'(4'($urandom_range(15))), int'($urandom), b);
    end
  endtask

  // Run one window from an IDLE negedge; compares every handshake against
  // the model, checks hold-under-backpressure and the done pulse.
  task automatic run_window(input address_t sa, input int cnt, input int ready_pct,
                            input bit stray_start);
    int      got;
    int      cycles;
    bit      fin;
    bit      hold;
    bit      stray_done;
    result_t h_res;
    address_t h_addr;
    build_expect(sa, cnt);
    obs_res.delete();
    obs_err.delete();
    obs_addr.delete();
    got = 0; cycles = 0; fin = 0; hold = 0; stray_done = 0;
    start = 1'b1; start_addr = sa; count = 6'(cnt); out_ready = 1'b0;
    tick();
    start = 1'b0;
    while (!fin && cycles < 20 * cnt + 20) begin
      if (done) begin
        check("done_after_last", 64'(got), 64'(cnt));
        if (cnt == 0) check("zero_done_latency", 64'(cycles), 64'(0));
        fin = 1;
      end else begin
        if (hold) begin
          check("hold_valid", 64'(out_valid), 64'(1));
          check("hold_res", 64'(out_res), 64'(h_res));
          check("hold_addr", 64'(out_addr), 64'(h_addr));
        end
        if (stray_start && got == 1 && !stray_done) begin
          start = 1'b1; start_addr = sa + address_t'(7); count = 6'd5;
          stray_done = 1;
        end
        out_ready = ($urandom_range(99) < ready_pct);
        if (out_valid) begin
          if (got >= expq.size()) begin
            check("extra_result", 64'(got), 64'(expq.size() - 1));
          end else if (out_ready) begin
            check("res_addr", 64'(out_addr), 64'(expq[got].addr));
            check("res_opcode", 64'(out_opcode), 64'(expq[got].opc));
            check("res_value", 64'(out_res), 64'(expq[got].res));
            check("res_err", 64'(out_err), 64'(expq[got].err));
            obs_res.push_back(out_res);
            obs_err.push_back(out_err);
            obs_addr.push_back(out_addr);
            got++;
            hold = 0;
          end else begin
            hold = 1; h_res = out_res; h_addr = out_addr;
          end
        end else begin
          hold = 0;
        end
      end
      tick();
      start = 1'b0;
      cycles++;
    end
    if (!fin) check("window_timeout", 64'(0), 64'(1));
    out_ready = 1'b0;
    check("post_done_low", 64'(done), 64'(0));
    check("post_busy_low", 64'(busy), 64'(0));
    check("post_valid_low", 64'(out_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    reset_n = 1'b0; start = 1'b0; start_addr = '0; count = '0;
    abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset values.
    tick();
    check("rst_rp", 64'(read_pointer), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_addr", 64'(out_addr), 64'(0));
    check("rst_opcode", 64'(out_opcode), 64'(ZERO));
    check("rst_res", 64'(out_res), 64'(0));
    check("rst_err", 64'(out_err), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset_n = 1'b1;
    tick();

    // Basic read with exact latency.
    mem[3] = mk(ADD, 7, -10);
    out_ready = 1'b1;
    start = 1'b1; start_addr = 5'd3; count = 6'd1;
    tick();
    start = 1'b0;
    check("basic_busy", 64'(busy), 64'(1));
    check("basic_rp", 64'(read_pointer), 64'(3));
    check("basic_valid_e0", 64'(out_valid), 64'(0));
    tick();
    check("basic_valid_e1", 64'(out_valid), 64'(0));
    tick();
    check("basic_valid_e2", 64'(out_valid), 64'(1));
    check("basic_res", 64'(out_res), 64'(-3));
    check("basic_addr", 64'(out_addr), 64'(3));
    check("basic_opcode", 64'(out_opcode), 64'(ADD));
    check("basic_err", 64'(out_err), 64'(0));
    check("basic_no_done", 64'(done), 64'(0));
    tick();
    check("basic_done", 64'(done), 64'(1));
    check("basic_valid_drop", 64'(out_valid), 64'(0));
    check("basic_rp_inc", 64'(read_pointer), 64'(4));
    tick();
    check("basic_done_pulse", 64'(done), 64'(0));
    check("basic_idle", 64'(busy), 64'(0));
    out_ready = 1'b0;

    // Backpressure: result held for five refused cycles.
    mem[5] = mk(MULT, 100000, 100000);
    start = 1'b1; start_addr = 5'd5; count = 6'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_res", 64'(out_res), 64'(64'sd10000000000));
      check("bp_no_done", 64'(done), 64'(0));
      tick();
    end
    check("bp_valid_last", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    tick();
    check("bp_accept_done", 64'(done), 64'(1));
    check("bp_accept_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b0;
    tick();

    // Window wrap across every arithmetic class.
    mem[30] = mk(SUB, 5, 9);
    mem[31] = mk(DIV, -7, 2);
    mem[0]  = mk(MOD, -7, 2);
    mem[1]  = mk(DIV, 4, 0);
    run_window(5'd30, 4, 100, 0);
    check("wrap_count", 64'(obs_res.size()), 64'(4));
    if (obs_res.size() == 4) begin
      check("wrap_addr0", 64'(obs_addr[0]), 64'(30));
      check("wrap_addr2", 64'(obs_addr[2]), 64'(0));
      check("wrap_res0", 64'(obs_res[0]), 64'(-4));
      check("wrap_res1", 64'(obs_res[1]), 64'(-3));
      check("wrap_res2", 64'(obs_res[2]), 64'(-1));
      check("wrap_res3", 64'(obs_res[3]), 64'(0));
      check("wrap_err2", 64'(obs_err[2]), 64'(0));
      check("wrap_err3", 64'(obs_err[3]), 64'(1));
    end

    // Zero count, then a stray start while busy.
    run_window(5'd9, 0, 100, 0);
    randomize_mem();
    run_window(5'd10, 3, 100, 1);

    // Abort and start in the same idle cycle: abort wins.
    start = 1'b1; abort = 1'b1; start_addr = 5'd2; count = 6'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'(0));
    check("abort_start_done", 64'(done), 64'(0));

    // Abort during the third OUTPUT.
    out_ready = 1'b1;
    start = 1'b1; start_addr = 5'd12; count = 6'd8;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && seen < 3; c++) begin
      if (out_valid) seen++;
      if (seen < 3) tick();
    end
    check("abort_reached", 64'(seen), 64'(3));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_rp", 64'(read_pointer), 64'(14));
    tick();
    check("abort_done_later", 64'(done), 64'(0));
    run_window(5'd20, 2, 100, 0);

    // Reset asserted in OUTPUT clears everything immediately.
    start = 1'b1; start_addr = 5'd0; count = 6'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("midrst_in_output", 64'(out_valid), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_rp", 64'(read_pointer), 64'(0));
    check("midrst_addr", 64'(out_addr), 64'(0));
    check("midrst_opcode", 64'(out_opcode), 64'(ZERO));
    check("midrst_res", 64'(out_res), 64'(0));
    check("midrst_err", 64'(out_err), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    tick();
    reset_n = 1'b1;
    tick();
    check("midrst_busy_after", 64'(busy), 64'(0));

    // Randomized windows, including full-depth and empty ones.
    for (int n = 0; n < 20; n++) begin
      int cnt;
      randomize_mem();
      case (n % 5)
        0:       cnt = 32;
        1:       cnt = 0;
        default: cnt = $urandom_range(32, 1);
      endcase
      run_window(address_t'($urandom_range(31)), cnt, $urandom_range(100, 30), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
